mtr_duty_shaper: RTL and testbench
==================================

Name: mtr_duty_shaper

Overview:
- Upstream stage of the 11-bit PWM generator. Converts a signed speed command into an unsigned 11-bit duty and direction enables.
- Applies per-PWM-period slew limiting and a forced dead interval on every direction reversal.
- Runs an internal 11-bit period counter, identical in timing to the PWM counter, so duty/direction change only at period boundaries.

Parameters:
- SLEW_STEP, 16: max change in duty magnitude per PWM period (1..2047).
- DEAD_PERIODS, 2: whole PWM periods held in DEAD on a reversal or stop (>=1).

Ports:
- clk, input, 1: system clock, 50 MHz.
- rst, input, 1: synchronous, active-high reset.
- cmd, input, 12: signed two's-complement speed command.
- cmd_vld, input, 1: cmd valid.
- cmd_rdy, output, 1: holding register empty; cmd accepted when cmd_vld && cmd_rdy.
- duty, output, 11: magnitude to the PWM generator.
- fwd, output, 1: forward bridge enable.
- rev, output, 1: reverse bridge enable.
- period_start, output, 1: 1-cycle pulse while internal cnt == 0.
- at_target, output, 1: state is DRIVE_F/DRIVE_R and duty == target magnitude.

Behaviour:
- Reset, synchronous on rst=1: cnt=0, state=IDLE, duty=0, fwd=0, rev=0, hold empty (cmd_rdy=1), target=0, dead_cnt=0, at_target=0. Applies identically mid-operation; a pending cmd is discarded.
- cnt: 11-bit, +1 every clk, wraps 2047->0. Boundary event B is defined as cnt==2047. All state/duty/fwd/rev updates occur only on B, so new values are visible from cnt==0.
- Handshake: an accepted cmd loads hold and drops cmd_rdy next cycle. On B, a full hold transfers to target and cmd_rdy rises next cycle. cmd_vld while cmd_rdy=0 is ignored.
- Magnitude: mag = |target|, saturated to 2047 (target = -2048 gives 2047). tdir = sign(target). A target of 0 has no direction.
- Ramp toward m: if duty<m, duty=min(duty+SLEW_STEP, m); if duty>m, duty=max(duty-SLEW_STEP, m). Compute with no 11-bit wrap, at least 12-bit internally.
- States and transitions, evaluated on B using the target value after the hold transfer on that same B:
  - IDLE: duty=0, fwd=rev=0. If mag!=0, enter DRIVE_F (tdir +) or DRIVE_R (tdir -) with duty=min(SLEW_STEP, mag).
  - DRIVE_F / DRIVE_R:
    - Target same direction and nonzero: ramp toward mag.
    - Target zero or opposite direction: ramp toward 0.
    - When the ramped duty equals 0 on this B: enter DEAD with dead_cnt=DEAD_PERIODS.
    - fwd=1 only in DRIVE_F; rev=1 only in DRIVE_R.
  - DEAD: duty=0, fwd=rev=0. Each B decrements dead_cnt; when the new value is 0, enter IDLE.
- Same-direction target changes never pass through DEAD.
- Invariant: fwd and rev are never both 1 unless BRAKE_EN is defined and the state is DEAD.
- at_target is registered and updated on B.

Optional Feature:
- Macro: MTR_BRAKE_EN.
- Defined: in DEAD, fwd=rev=1 (low-side brake) and duty=0.
- Undefined: in DEAD, fwd=rev=0 (coast).
- All other behaviour is identical in both builds.

Test Plan:
- Reset/idle: assert rst 3 cycles, release -> duty=0, fwd=rev=0, cmd_rdy=1, period_start at clk 0, 2048, 4096 after release.
- Ramp up: cmd=+100, vld 1 cycle before first B -> at successive B: IDLE->DRIVE_F duty=16, then 32, 48, 64, 80, 96, 100. at_target=1 after the 7th B; no change inside any period.
- Reversal, DEAD_PERIODS=2:
  - From +100 steady, cmd=-50 -> duty 84, 68, 52, 36, 20, 4, then 0 with DEAD on the 7th B.
  - fwd=rev=0 for 2 periods, IDLE for 1 period, then DRIVE_R with duty=16, 32, 48, 50 and rev=1.
- Saturation/handshake:
  - cmd=-2048 -> mag 2047; ramp ends at duty=2047, rev=1.
  - A second cmd while cmd_rdy=0 is ignored; cmd_rdy returns 1 the cycle after B.
- Reset mid-ramp: rst at cnt=1000 during DRIVE_F duty=48 -> next cycle duty=0, fwd=0, IDLE, cnt=0, pending hold dropped.
- MTR_BRAKE_EN build: repeat the reversal test -> during DEAD fwd=rev=1, duty=0; in every other state fwd&rev==0.

Source files
------------

// File: rtl/mtr_duty_shaper.sv
// -----------------------------------------------------------------------------
// mtr_duty_shaper
//
// Upstream stage of the 11-bit PWM generator. Converts a signed speed command
// into an unsigned 11-bit duty magnitude plus forward/reverse bridge enables.
// The duty is slew limited once per PWM period. Every direction reversal, and
// every stop, passes through a forced dead interval of whole PWM periods.
//
// An internal 11-bit period counter runs in lock-step with the PWM counter.
// State, duty and direction change only on the last count of a period
// (cnt == 2047), so new values are seen by the PWM stage from cnt == 0.
//
// Build option:
//   MTR_BRAKE_EN  defined   -> DEAD drives fwd = rev = 1 (low-side brake)
//                 undefined -> DEAD drives fwd = rev = 0 (coast)
//
// Parameters:
//   SLEW_STEP     max change of duty magnitude per PWM period (1..2047)
//   DEAD_PERIODS  whole PWM periods spent in DEAD on reversal/stop (>= 1)
//
// Ports:
//   clk           system clock (50 MHz)
//   rst           synchronous, active-high reset
//   cmd[11:0]     signed two's-complement speed command
//   cmd_vld       cmd valid
//   cmd_rdy       holding register empty; cmd taken when cmd_vld && cmd_rdy
//   duty[10:0]    magnitude to the PWM generator
//   fwd           forward bridge enable
//   rev           reverse bridge enable
//   period_start  high for the one cycle where the period counter is 0
//   at_target     driving and duty equals the target magnitude
// -----------------------------------------------------------------------------
module mtr_duty_shaper #(
    parameter int SLEW_STEP    = 16,
    parameter int DEAD_PERIODS = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] cmd,
    input  logic        cmd_vld,
    output logic        cmd_rdy,
    output logic [10:0] duty,
    output logic        fwd,
    output logic        rev,
    output logic        period_start,
    output logic        at_target
);

    localparam int              DW        = $clog2(DEAD_PERIODS + 1);
    localparam logic [11:0]     STEP_C    = 12'(SLEW_STEP);
    localparam logic [DW-1:0]   DEAD_INIT = DW'(DEAD_PERIODS);
    localparam logic [DW-1:0]   DEAD_ONE  = DW'(1);
    localparam logic [DW-1:0]   DEAD_ZERO = DW'(0);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DRIVE_F = 2'd1,
        ST_DRIVE_R = 2'd2,
        ST_DEAD    = 2'd3
    } state_t;

    // Magnitude of a signed command; -2048 has no 11-bit magnitude and
    // saturates to 2047.
    function automatic logic [10:0] sat_mag(input logic [11:0] t);
        logic [11:0] neg;
        neg = (~t) + 12'd1;
        if (t == 12'h800) begin
            return 11'h7FF;
        end else if (t[11]) begin
            return neg[10:0];
        end else begin
            return t[10:0];
        end
    endfunction

    // One slew step from cur toward goal. Done in 12 bits so that a step
    // past 2047 clamps to the goal instead of wrapping.
    function automatic logic [10:0] ramp(input logic [10:0] cur,
                                         input logic [10:0] goal);
        logic [11:0] c12;
        logic [11:0] g12;
        logic [11:0] r12;
        c12 = {1'b0, cur};
        g12 = {1'b0, goal};
        if (c12 < g12) begin
            r12 = c12 + STEP_C;
            if (r12 > g12) begin
                r12 = g12;
            end else begin
                r12 = r12;
            end
        end else if (c12 > g12) begin
            if (c12 > (g12 + STEP_C)) begin
                r12 = c12 - STEP_C;
            end else begin
                r12 = g12;
            end
        end else begin
            r12 = c12;
        end
        return r12[10:0];
    endfunction

    logic [10:0]   cnt_r;
    logic          period_start_r;
    logic [11:0]   hold_r;
    logic          hold_empty_r;
    logic [11:0]   target_r;
    state_t        state_r;
    logic [10:0]   duty_r;
    logic          fwd_r;
    logic          rev_r;
    logic          at_target_r;
    logic [DW-1:0] dead_cnt_r;

    logic          bnd_s;
    logic          accept_s;
    logic [11:0]   tgt_eff_s;
    logic [10:0]   mag_s;
    logic          tneg_s;
    logic [10:0]   goal_s;
    state_t        state_nx_s;
    logic [10:0]   duty_nx_s;
    logic [DW-1:0] dead_nx_s;
    logic          fwd_nx_s;
    logic          rev_nx_s;
    logic          at_nx_s;

    assign bnd_s        = (cnt_r == 11'd2047);
    assign accept_s     = cmd_vld & hold_empty_r;
    assign cmd_rdy      = hold_empty_r;
    assign duty         = duty_r;
    assign fwd          = fwd_r;
    assign rev          = rev_r;
    assign period_start = period_start_r;
    assign at_target    = at_target_r;

    // Free-running period counter; period_start marks the cycle where it is 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r          <= 11'd0;
            period_start_r <= 1'b1;
        end else begin
            cnt_r          <= cnt_r + 11'd1;
            period_start_r <= bnd_s;
        end
    end

    // Command holding register; a full hold is moved to target on the boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_r       <= 12'd0;
            hold_empty_r <= 1'b1;
            target_r     <= 12'd0;
        end else if (bnd_s && !hold_empty_r) begin
            target_r     <= hold_r;
            hold_empty_r <= 1'b1;
        end else if (accept_s) begin
            hold_r       <= cmd;
            hold_empty_r <= 1'b0;
        end else begin
            hold_r       <= hold_r;
            hold_empty_r <= hold_empty_r;
        end
    end

    // Target seen by the FSM on a boundary includes that boundary's transfer.
    always_comb begin
        tgt_eff_s = target_r;
        if (!hold_empty_r) begin
            tgt_eff_s = hold_r;
        end else begin
            tgt_eff_s = target_r;
        end
        mag_s  = sat_mag(tgt_eff_s);
        tneg_s = tgt_eff_s[11];
    end

    // FSM next state, next duty and next bridge enables.
    always_comb begin
        state_nx_s = state_r;
        duty_nx_s  = duty_r;
        dead_nx_s  = dead_cnt_r;
        goal_s     = 11'd0;
        case (state_r)
            ST_IDLE: begin
                if (mag_s != 11'd0) begin
                    duty_nx_s  = ramp(11'd0, mag_s);
                    state_nx_s = tneg_s ? ST_DRIVE_R : ST_DRIVE_F;
                end else begin
                    duty_nx_s  = 11'd0;
                    state_nx_s = ST_IDLE;
                end
            end
            ST_DRIVE_F, ST_DRIVE_R: begin
                // Keep ramping toward the magnitude only while the target
                // still points the way we are driving; otherwise head for 0.
                if ((mag_s != 11'd0) && (tneg_s == (state_r == ST_DRIVE_R))) begin
                    goal_s = mag_s;
                end else begin
                    goal_s = 11'd0;
                end
                duty_nx_s = ramp(duty_r, goal_s);
                if (duty_nx_s == 11'd0) begin
                    state_nx_s = ST_DEAD;
                    dead_nx_s  = DEAD_INIT;
                end else begin
                    state_nx_s = state_r;
                end
            end
            ST_DEAD: begin
                duty_nx_s = 11'd0;
                dead_nx_s = dead_cnt_r - DEAD_ONE;
                if (dead_nx_s == DEAD_ZERO) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_DEAD;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
                duty_nx_s  = 11'd0;
                dead_nx_s  = DEAD_ZERO;
            end
        endcase
    end

    // Bridge enables and at_target derived from the state being entered.
    always_comb begin
        fwd_nx_s = 1'b0;
        rev_nx_s = 1'b0;
        case (state_nx_s)
            ST_DRIVE_F: begin
                fwd_nx_s = 1'b1;
                rev_nx_s = 1'b0;
            end
            ST_DRIVE_R: begin
                fwd_nx_s = 1'b0;
                rev_nx_s = 1'b1;
            end
            ST_DEAD: begin
`ifdef MTR_BRAKE_EN
                fwd_nx_s = 1'b1;
                rev_nx_s = 1'b1;
`else
                fwd_nx_s = 1'b0;
                rev_nx_s = 1'b0;
`endif
            end
            default: begin
                fwd_nx_s = 1'b0;
                rev_nx_s = 1'b0;
            end
        endcase
        at_nx_s = ((state_nx_s == ST_DRIVE_F) || (state_nx_s == ST_DRIVE_R)) &&
                  (duty_nx_s == mag_s);
    end

    // FSM and output registers; they move only on the period boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            duty_r      <= 11'd0;
            fwd_r       <= 1'b0;
            rev_r       <= 1'b0;
            at_target_r <= 1'b0;
            dead_cnt_r  <= DEAD_ZERO;
        end else if (bnd_s) begin
            state_r     <= state_nx_s;
            duty_r      <= duty_nx_s;
            fwd_r       <= fwd_nx_s;
            rev_r       <= rev_nx_s;
            at_target_r <= at_nx_s;
            dead_cnt_r  <= dead_nx_s;
        end else begin
            state_r     <= state_r;
            duty_r      <= duty_r;
            fwd_r       <= fwd_r;
            rev_r       <= rev_r;
            at_target_r <= at_target_r;
            dead_cnt_r  <= dead_cnt_r;
        end
    end

endmodule

// File: tb/tb_mtr_duty_shaper.sv
// -----------------------------------------------------------------------------
// tb_mtr_duty_shaper
//
// Directed bench for mtr_duty_shaper. Two instances share clk and rst:
//   dut  : SLEW_STEP=16,   DEAD_PERIODS=2 (reset, ramp, reversal, handshake)
//   dut2 : SLEW_STEP=1000, DEAD_PERIODS=1 (saturation at -2048, 12-bit clamp)
// Expected per-period outputs are queued when a command is driven and popped
// at each following period start.
// -----------------------------------------------------------------------------
module tb_mtr_duty_shaper;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] cmd;
    logic        cmd_vld;
    logic        cmd_rdy;
    logic [10:0] duty;
    logic        fwd;
    logic        rev;
    logic        period_start;
    logic        at_target;

    logic [11:0] cmd2;
    logic        cmd_vld2;
    logic        cmd_rdy2;
    logic [10:0] duty2;
    logic        fwd2;
    logic        rev2;
    logic        period_start2;
    logic        at_target2;

`ifdef MTR_BRAKE_EN
    localparam logic BRK = 1'b1;
`else
    localparam logic BRK = 1'b0;
`endif

    typedef struct packed {
        logic [10:0] duty;
        logic        fwd;
        logic        rev;
        logic        at;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    always #10 clk = ~clk;

    mtr_duty_shaper #(.SLEW_STEP(16), .DEAD_PERIODS(2)) dut (
        .clk(clk), .rst(rst), .cmd(cmd), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
        .duty(duty), .fwd(fwd), .rev(rev), .period_start(period_start),
        .at_target(at_target)
    );

    mtr_duty_shaper #(.SLEW_STEP(1000), .DEAD_PERIODS(1)) dut2 (
        .clk(clk), .rst(rst), .cmd(cmd2), .cmd_vld(cmd_vld2), .cmd_rdy(cmd_rdy2),
        .duty(duty2), .fwd(fwd2), .rev(rev2), .period_start(period_start2),
        .at_target(at_target2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock; cyc mirrors the DUT period counter (cnt == cyc % 2048).
    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic goto_cnt(input int c);
        do step(); while ((cyc % 2048) != c);
    endtask

    task automatic push(input logic [10:0] d, input logic f, input logic r, input logic a);
        exp_t e;
        e.duty = d;
        e.fwd  = f;
        e.rev  = r;
        e.at   = a;
        sb_q.push_back(e);
    endtask

    task automatic sample(input int u, output logic [10:0] d, output logic f,
                          output logic r, output logic a, output logic ps,
                          output logic rd);
        if (u == 0) begin
            d = duty; f = fwd; r = rev; a = at_target; ps = period_start; rd = cmd_rdy;
        end else begin
            d = duty2; f = fwd2; r = rev2; a = at_target2; ps = period_start2; rd = cmd_rdy2;
        end
    endtask

    // Check the next period: values at cnt 0, then unchanged mid-period.
    task automatic chk_period(input string tag, input int u);
        exp_t        e;
        logic [10:0] d;
        logic        f, r, a, ps, rd;
        goto_cnt(0);
        n_tests++;
        assert (sb_q.size() != 0) else begin
            n_fail++;
            $error("FAIL %s.sb_empty: observed 0 entries expected >0", tag);
        end
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            sample(u, d, f, r, a, ps, rd);
            chk($sformatf("%s.duty", tag), 32'(d), 32'(e.duty));
            chk($sformatf("%s.fwd", tag), 32'(f), 32'(e.fwd));
            chk($sformatf("%s.rev", tag), 32'(r), 32'(e.rev));
            chk($sformatf("%s.at_target", tag), 32'(a), 32'(e.at));
            chk($sformatf("%s.period_start", tag), 32'(ps), 32'd1);
            chk($sformatf("%s.cmd_rdy_after_B", tag), 32'(rd), 32'd1);
            goto_cnt(1024);
            sample(u, d, f, r, a, ps, rd);
            chk($sformatf("%s.duty_mid", tag), 32'(d), 32'(e.duty));
            chk($sformatf("%s.fwd_mid", tag), 32'(f), 32'(e.fwd));
            chk($sformatf("%s.rev_mid", tag), 32'(r), 32'(e.rev));
            chk($sformatf("%s.ps_mid", tag), 32'(ps), 32'd0);
        end else begin
            goto_cnt(1024);
        end
    endtask

    initial begin
        rst      = 1'b1;
        cmd      = 12'd0;
        cmd_vld  = 1'b0;
        cmd2     = 12'd0;
        cmd_vld2 = 1'b0;

        // Reset / idle
        repeat (3) @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        chk("rst.duty", 32'(duty), 32'd0);
        chk("rst.fwd", 32'(fwd), 32'd0);
        chk("rst.rev", 32'(rev), 32'd0);
        chk("rst.cmd_rdy", 32'(cmd_rdy), 32'd1);
        chk("rst.at_target", 32'(at_target), 32'd0);
        chk("rst.period_start0", 32'(period_start), 32'd1);
        chk("rst.duty2", 32'(duty2), 32'd0);
        step();
        chk("rst.period_start1", 32'(period_start), 32'd0);
        goto_cnt(2047);
        chk("rst.period_start2047", 32'(period_start), 32'd0);
        goto_cnt(0);
        chk("rst.period_start2048", 32'(period_start), 32'd1);
        chk("rst.idle_duty2048", 32'(duty), 32'd0);
        goto_cnt(0);
        chk("rst.period_start4096", 32'(period_start), 32'd1);

        // Reset mid-ramp: ramp to 48, leave a command pending, reset at cnt 1000
        goto_cnt(2046);
        cmd = 12'd100; cmd_vld = 1'b1;
        step();
        cmd_vld = 1'b0;
        chk("mid.cmd_rdy_low", 32'(cmd_rdy), 32'd0);
        push(11'd16, 1'b1, 1'b0, 1'b0);
        push(11'd32, 1'b1, 1'b0, 1'b0);
        push(11'd48, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) chk_period($sformatf("mid_ramp%0d", i), 0);
        goto_cnt(990);
        cmd = 12'hFF9; cmd_vld = 1'b1;
        step();
        cmd_vld = 1'b0;
        chk("mid.pending", 32'(cmd_rdy), 32'd0);
        goto_cnt(1000);
        rst = 1'b1;
        step();
        rst = 1'b0;
        cyc = 0;
        chk("mid.rst_duty", 32'(duty), 32'd0);
        chk("mid.rst_fwd", 32'(fwd), 32'd0);
        chk("mid.rst_rev", 32'(rev), 32'd0);
        chk("mid.rst_cmd_rdy", 32'(cmd_rdy), 32'd1);
        chk("mid.rst_cnt0", 32'(period_start), 32'd1);
        chk("mid.rst_at", 32'(at_target), 32'd0);
        push(11'd0, 1'b0, 1'b0, 1'b0);
        chk_period("mid_dropped", 0);

        // Ramp up to +100
        goto_cnt(2046);
        cmd = 12'd100; cmd_vld = 1'b1;
        step();
        cmd_vld = 1'b0;
        chk("up.cmd_rdy_low", 32'(cmd_rdy), 32'd0);
        for (int i = 1; i <= 6; i++) push(11'(16 * i), 1'b1, 1'b0, 1'b0);
        push(11'd100, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) chk_period($sformatf("up%0d", i), 0);

        // Reversal to -50; a second command while the hold is full is ignored
        goto_cnt(1500);
        cmd = 12'hFCE; cmd_vld = 1'b1;
        step();
        cmd_vld = 1'b0;
        goto_cnt(1600);
        chk("rev.cmd_rdy_low", 32'(cmd_rdy), 32'd0);
        cmd = 12'd300; cmd_vld = 1'b1;
        step();
        cmd_vld = 1'b0;
        goto_cnt(2047);
        chk("rev.cmd_rdy_pre_B", 32'(cmd_rdy), 32'd0);
        for (int i = 0; i < 6; i++) push(11'(84 - 16 * i), 1'b1, 1'b0, 1'b0);
        push(11'd0, BRK, BRK, 1'b0);
        push(11'd0, BRK, BRK, 1'b0);
        push(11'd0, 1'b0, 1'b0, 1'b0);
        push(11'd16, 1'b0, 1'b1, 1'b0);
        push(11'd32, 1'b0, 1'b1, 1'b0);
        push(11'd48, 1'b0, 1'b1, 1'b0);
        push(11'd50, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 13; i++) chk_period($sformatf("rev%0d", i), 0);

        // Saturation on the wide-step instance: -2048 -> 1000, 2000, 2047
        goto_cnt(2046);
        cmd2 = 12'h800; cmd_vld2 = 1'b1;
        step();
        cmd_vld2 = 1'b0;
        chk("sat.cmd_rdy_low", 32'(cmd_rdy2), 32'd0);
        push(11'd1000, 1'b0, 1'b1, 1'b0);
        push(11'd2000, 1'b0, 1'b1, 1'b0);
        push(11'd2047, 1'b0, 1'b1, 1'b1);
        push(11'd2047, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) chk_period($sformatf("sat%0d", i), 1);
        chk("sat.dut_steady_duty", 32'(duty), 32'd50);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
